// File: rtl/pc_bus_pkg.sv
// Shared PC bus-unit definitions: INTA sequencer state encoding and default
// INTA timing so the bus-unit timing model and the sequencer agree.
package pc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK1,
    ST_GAP,
    ST_ACK2,
    ST_HOLD
  } inta_state_e;

  localparam int INTA_PULSE_CYCLES = 2;
  localparam int INTA_GAP_CYCLES   = 2;
  localparam int INTA_SYNC_STAGES  = 2;

  // Counter only ever needs to reach max(pulse, gap) - 1; it reloads per state.
  function automatic int inta_cnt_width(input int pulse, input int gap);
    return $clog2(((pulse > gap) ? pulse : gap) + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flip-flop synchroniser for asynchronous single-bit inputs.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] r_chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_chain <= '0;
    else       r_chain <= {r_chain[N-2:0], d};
  end

  assign q = r_chain[N-1];

endmodule

// File: rtl/intack_seq.sv
// 8088-style interrupt acknowledge sequencer: two INTA pulses to the 8259,
// captures the vector on the second pulse, hands it to the CPU via valid/ready.
module intack_seq
  import pc_bus_pkg::*;
#(
  parameter int PULSE_CYCLES = INTA_PULSE_CYCLES,
  parameter int GAP_CYCLES   = INTA_GAP_CYCLES,
  parameter int SYNC_STAGES  = INTA_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       intr,
  input  logic       if_en,
  input  logic       inst_boundary,
  input  logic [7:0] d,
  output logic       inta_n,
  output logic       lock_n,
  output logic [7:0] vec,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic       busy
);

  localparam int CW = inta_cnt_width(PULSE_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  logic          w_intr_s;
  inta_state_e   r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_capture;
  logic          r_inta_n, r_lock_n, r_vec_valid, r_busy;
  logic [7:0]    r_vec;

  sync_ff #(.N(SYNC_STAGES)) u_intr_sync (
    .clk   (clk),
    .reset (reset),
    .d     (intr),
    .q     (w_intr_s)
  );

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt + CW'(1);
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_intr_s && if_en && inst_boundary) w_nxt = ST_ACK1;
      end
      ST_ACK1: if (r_cnt == PULSE_LAST) begin
        w_nxt     = ST_GAP;
        w_cnt_nxt = '0;
      end
      ST_GAP: if (r_cnt == GAP_LAST) begin
        w_nxt     = ST_ACK2;
        w_cnt_nxt = '0;
      end
      ST_ACK2: if (r_cnt == PULSE_LAST) begin
        w_nxt     = ST_HOLD;
        w_cnt_nxt = '0;
        w_capture = 1'b1;
      end
      ST_HOLD: begin
        w_cnt_nxt = '0;
        if (vec_ready) w_nxt = ST_IDLE;
      end
      default: begin
        w_nxt     = ST_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inta_n    <= 1'b1;
      r_lock_n    <= 1'b1;
      r_vec_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_vec       <= 8'h00;
    end else begin
      r_inta_n    <= !(w_nxt == ST_ACK1 || w_nxt == ST_ACK2);
      r_lock_n    <= !(w_nxt == ST_ACK1 || w_nxt == ST_GAP || w_nxt == ST_ACK2);
      r_vec_valid <= (w_nxt == ST_HOLD);
      r_busy      <= (w_nxt != ST_IDLE);
      if (w_capture) r_vec <= d;
    end
  end

  assign inta_n    = r_inta_n;
  assign lock_n    = r_lock_n;
  assign vec       = r_vec;
  assign vec_valid = r_vec_valid;
  assign busy      = r_busy;

endmodule
